// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat dealer.
// Optional build macro: BACCARAT_CARD_FILTER_EN (see baccarat_dealer).
package baccarat_pkg;

   typedef logic [3:0] card_t;

   typedef enum logic [3:0] {
      IDLE,
      P1,
      B1,
      P2,
      B2,
      EVAL,
      P3,
      B3,
      DONE
   } dealer_state_t;

   localparam logic [3:0] NATURAL_MIN = 4'd8;
   localparam logic [3:0] DRAW_MAX    = 4'd5;

   function automatic logic [3:0] card_points(input card_t c);
      return (c >= 4'd10) ? 4'd0 : c;
   endfunction

   // Hand value: sum of up to three card points, reduced mod 10 (max 27).
   function automatic logic [3:0] hand_score(
      input card_t a,
      input card_t b,
      input card_t c
   );
      logic [4:0] s;
      s = {1'b0, card_points(a)}
        + {1'b0, card_points(b)}
        + {1'b0, card_points(c)};
      if (s >= 5'd20)
         s = s - 5'd20;
      else if (s >= 5'd10)
         s = s - 5'd10;
      return s[3:0];
   endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// Banker third-card decision once the player has drawn a third card.
// Purely combinational; v is the point value of the player's third card.
module baccarat_banker_rule
   import baccarat_pkg::*;
(
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3_points,
   output logic       banker_draws
);

   logic [3:0] v;
   assign v = pcard3_points;

   always_comb begin
      banker_draws = 1'b0;
      unique case (1'b1)
         (dscore <= 4'd2): banker_draws = 1'b1;
         (dscore == 4'd3): banker_draws = (v != 4'd8);
         (dscore == 4'd4): banker_draws = (v >= 4'd2) && (v <= 4'd7);
         (dscore == 4'd5): banker_draws = (v >= 4'd4) && (v <= 4'd7);
         (dscore == 4'd6): banker_draws = (v >= 4'd6) && (v <= 4'd7);
         default:          banker_draws = 1'b0;
      endcase
   end

endmodule

// File: rtl/baccarat_dealer.sv
// Sequential baccarat round dealer: pulls cards, applies drawing rules, flags winner.
// Build macro BACCARAT_CARD_FILTER_EN: discard handshaked ranks 0 and 14..15.
module baccarat_dealer
   import baccarat_pkg::*;
(
   input  logic       slow_clock,
   input  logic       reset,
   input  logic       start,
   input  logic       card_valid,
   input  logic [3:0] card_in,
   output logic       card_req,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic       player_win,
   output logic       dealer_win,
   output logic       busy,
   output logic       done
);

   dealer_state_t state, state_n;
   logic          clr;
   logic          wr;
   logic          card_ok;
   logic          banker_draws;
   logic [3:0]    p3_points;

`ifdef BACCARAT_CARD_FILTER_EN
   assign card_ok = (card_in >= 4'd1) && (card_in <= 4'd13);
`else
   assign card_ok = 1'b1;
`endif

   assign pscore = hand_score(pcard1, pcard2, pcard3);
   assign dscore = hand_score(dcard1, dcard2, dcard3);

   // Decided in the P3 cycle from the incoming card, before it lands in pcard3.
   assign p3_points = card_points(card_in);

   baccarat_banker_rule u_rule (
      .dscore        (dscore),
      .pcard3_points (p3_points),
      .banker_draws  (banker_draws)
   );

   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state  <= IDLE;
         pcard1 <= '0;
         pcard2 <= '0;
         pcard3 <= '0;
         dcard1 <= '0;
         dcard2 <= '0;
         dcard3 <= '0;
      end else begin
         state <= state_n;
         if (clr) begin
            pcard1 <= '0;
            pcard2 <= '0;
            pcard3 <= '0;
            dcard1 <= '0;
            dcard2 <= '0;
            dcard3 <= '0;
         end else if (wr) begin
            case (state)
               P1:      pcard1 <= card_in;
               B1:      dcard1 <= card_in;
               P2:      pcard2 <= card_in;
               B2:      dcard2 <= card_in;
               P3:      pcard3 <= card_in;
               B3:      dcard3 <= card_in;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_n  = state;
      card_req = 1'b0;
      clr      = 1'b0;
      wr       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               clr     = 1'b1;
               state_n = P1;
            end
         end
         P1, B1, P2, B2, P3, B3: begin
            card_req = 1'b1;
            if (card_valid && card_ok) begin
               wr = 1'b1;
               case (state)
                  P1:      state_n = B1;
                  B1:      state_n = P2;
                  P2:      state_n = B2;
                  B2:      state_n = EVAL;
                  P3:      state_n = banker_draws ? B3 : DONE;
                  default: state_n = DONE;
               endcase
            end
         end
         EVAL: begin
            if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN))
               state_n = DONE;
            else if (pscore <= DRAW_MAX)
               state_n = P3;
            else if (dscore <= DRAW_MAX)
               state_n = B3;
            else
               state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy       = (state != IDLE) && (state != DONE);
   assign done       = (state == DONE);
   assign player_win = done && (pscore >= dscore);
   assign dealer_win = done && (dscore >= pscore);

endmodule
